// File: rtl/mant_div_24bit_pkg.sv
// Shared constants for the 24-bit mantissa divider: widths, FSM encodings and
// the quotient pattern reported when the divisor is not normalized.
package mant_div_24bit_pkg;

    localparam int WIDTH = 24;
    localparam int QBITS = WIDTH + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [QBITS-1:0] DBZ_Q = '1;

    // A divisor is usable only when its hidden bit is set.
    function automatic logic is_normalized(input logic [WIDTH-1:0] d);
        return d[WIDTH-1];
    endfunction

endpackage

// File: rtl/mant_div_24bit_nr_div_step.sv
// One radix-2 non-restoring iteration on a signed partial remainder.
// shift=0 is used only for the first iteration so the integer quotient bit lines up.
module nr_div_step #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH+1:0] rem,
    input  logic [WIDTH-1:0] b,
    input  logic             shift,
    output logic [WIDTH+1:0] next_rem,
    output logic             qbit
);

    logic [WIDTH+1:0] base;
    logic [WIDTH+1:0] b_ext;

    // |rem| < b <= 2^WIDTH, so doubling never disturbs the sign bit.
    always_comb begin
        base     = shift ? {rem[WIDTH:0], 1'b0} : rem;
        b_ext    = {2'b00, b};
        next_rem = rem[WIDTH+1] ? (base + b_ext) : (base - b_ext);
        qbit     = ~next_rem[WIDTH+1];
    end

endmodule

// File: rtl/mant_div_24bit.sv
// Sequential non-restoring mantissa divider: one quotient bit per clock,
// 1.(QBITS-1) quotient plus sticky, valid/ready on both sides.
module mant_div_24bit
    import mant_div_24bit_pkg::*;
#(
    parameter int WIDTH = mant_div_24bit_pkg::WIDTH,
    parameter int QBITS = WIDTH + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [QBITS-1:0] q,
    output logic             sticky,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready is high only in IDLE, out_valid only in DONE.

    localparam int CBITS = $clog2(QBITS);
    localparam logic [CBITS-1:0] LAST_COUNT = CBITS'(QBITS - 1);

    logic [1:0]       state;
    logic [CBITS-1:0] count;
    logic [WIDTH+1:0] rem;
    logic [WIDTH-1:0] div;
    logic [QBITS-1:0] q_acc;

    logic [WIDTH+1:0] step_rem;
    logic             step_qbit;
    logic             step_shift;
    logic [WIDTH+1:0] fixed_rem;

    assign step_shift = (count != '0);

    nr_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem     (rem),
        .b       (div),
        .shift   (step_shift),
        .next_rem(step_rem),
        .qbit    (step_qbit)
    );

    // Quotient bits are already exact; only the remainder needs restoring.
    always_comb begin
        fixed_rem = rem;
        if (rem[WIDTH+1]) begin
            fixed_rem = rem + {2'b00, div};
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            count       <= '0;
            rem         <= '0;
            div         <= '0;
            q_acc       <= '0;
            q           <= '0;
            sticky      <= 1'b0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        div   <= b;
                        rem   <= {2'b00, a};
                        count <= '0;
                        q_acc <= '0;
                        if (!b[WIDTH-1]) begin
                            div_by_zero <= 1'b1;
                            q           <= '1;
                            sticky      <= 1'b0;
                            out_valid   <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            div_by_zero <= 1'b0;
                            state       <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem   <= step_rem;
                    q_acc <= {q_acc[QBITS-2:0], step_qbit};
                    if (count == LAST_COUNT) begin
                        state <= S_FIX;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_FIX: begin
                    q         <= q_acc;
                    sticky    <= |fixed_rem;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mant_div_24bit.sv
// Directed and random stimulus for mant_div_24bit against an arithmetic
// reference (floor division and remainder of a*2^25 by b).
module tb_mant_div_24bit;
    import mant_div_24bit_pkg::*;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              out_valid;
    logic              out_ready;
    logic [QBITS-1:0]  q;
    logic              sticky;
    logic              div_by_zero;
    logic [1:0]        dbg_state;

    int n_cmp;
    int n_err;
    int lat;

    mant_div_24bit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .q          (q),
        .sticky     (sticky),
        .div_by_zero(div_by_zero),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: quotient and remainder of a * 2^(QBITS-1) divided by b.
    task automatic ref_div(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                           output logic [QBITS-1:0] eq, output logic es, output logic ez);
        longint unsigned num;
        longint unsigned den;
        if (rb < 24'h800000) begin
            eq = '1;
            es = 1'b0;
            ez = 1'b1;
        end else begin
            num = longint'(ra) << (QBITS - 1);
            den = longint'(rb);
            eq  = QBITS'(num / den);
            es  = ((num % den) != 0);
            ez  = 1'b0;
        end
    endtask

    // Issues one divide, measures edges from accept (accept edge counted as 1)
    // to out_valid, checks the result, holds backpressure, then drains it.
    task automatic run_div(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                           input int hold, output int latency);
        logic [QBITS-1:0] eq;
        logic             es;
        logic             ez;
        int               guard;
        ref_div(ta, tbv, eq, es, ez);
        @(negedge clk);
        a        = ta;
        b        = tbv;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        latency  = 1;
        while (!out_valid && latency < 100) begin
            @(negedge clk);
            latency++;
        end
        check("out_valid_seen", {31'd0, out_valid}, 32'd1);
        check("q", 32'(q), 32'(eq));
        check("sticky", {31'd0, sticky}, {31'd0, es});
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, ez});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_q", 32'(q), 32'(eq));
            check("hold_sticky", {31'd0, sticky}, {31'd0, es});
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_sticky", {31'd0, sticky}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        rst = 1'b0;

        run_div(24'h800000, 24'h800000, 0, lat);
        check("lat_unit", lat, 28);
        run_div(24'hFFFFFF, 24'h800000, 0, lat);
        run_div(24'h800000, 24'hC00000, 5, lat);
        run_div(24'h123456, 24'h000000, 0, lat);
        check("lat_dbz", lat, 1);
        run_div(24'hFFFFFF, 24'h7FFFFF, 2, lat);
        run_div(24'h000000, 24'hABCDEF, 0, lat);
        run_div(24'hFFFFFF, 24'hFFFFFF, 0, lat);
        run_div(24'h000001, 24'hFFFFFF, 0, lat);

        // Reset ten cycles into CALC discards the divide.
        @(negedge clk);
        a        = 24'hFFFFFF;
        b        = 24'h900000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_q", 32'(q), 32'd0);
        check("mid_rst_sticky", {31'd0, sticky}, 32'd0);
        check("mid_rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
        run_div(24'h800000, 24'hC00000, 0, lat);
        check("lat_after_rst", lat, 28);

        for (int i = 0; i < 24; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom) | 24'h800000;
            if (i % 8 == 7) rb = WIDTH'($urandom_range(0, 24'h7FFFFF));
            run_div(ra, rb, $urandom_range(0, 2), lat);
            check("lat_rand", lat, (rb[WIDTH-1] ? 28 : 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
